// File: rtl/sprite_frame_sequencer.sv
// Frame-synchronous shadow/active register bank for the sprite renderer, plus
// frame-locked animation phase counters advanced at the start of vertical blank.
module sprite_frame_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int DATA_W    = 10,
  parameter int CTRL_ADDR = 15,
  parameter int HTOTAL    = 1600,
  parameter int VACTIVE   = 480,
  parameter int ANIM_DIV  = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic [8:0]                 address,
  input  logic [31:0]                writedata,
  input  logic [10:0]                hcount,
  input  logic [9:0]                 vcount,
  output logic [NUM_REGS*DATA_W-1:0] active_regs,
  output logic                       commit_pulse,
  output logic                       pending,
  output logic [15:0]                frame_count,
  output logic [1:0]                 walk_phase,
  output logic                       flap_phase
);

  localparam int BW = NUM_REGS * DATA_W;
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic                vb_start_s, data_wr_s, ctrl_wr_s, commit_s, anim_run_s, anim_wrap_s;
  logic [BW-1:0]       shadow_q, shadow_d, active_q, active_d;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic                commit_pulse_q, commit_pulse_d, pending_q, pending_d;
  logic [15:0]         frame_q, frame_d;
  logic [AW-1:0]       anim_q, anim_d;
  logic [1:0]          walk_q, walk_d;
  logic                flap_q, flap_d;
  logic                unused_wd_s;

  assign unused_wd_s = ^writedata[31:DATA_W];

  // Bus decode and frame-boundary detection; FREEZE/PAUSE use the pre-edge control value.
  always_comb begin
    vb_start_s  = (hcount == 11'(HTOTAL - 1)) && (vcount == 10'(VACTIVE - 1));
    data_wr_s   = chipselect && write && (address < 9'(NUM_REGS)) && (address != 9'(CTRL_ADDR));
    ctrl_wr_s   = chipselect && write && (address == 9'(CTRL_ADDR));
    commit_s    = vb_start_s && !ctrl_q[0];
    anim_run_s  = vb_start_s && !ctrl_q[1];
    anim_wrap_s = anim_run_s && (anim_q == AW'(ANIM_DIV - 1));
  end

  // Bank next-state: commit copies the old shadow, then a same-cycle write re-dirties its register.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    if (commit_s) begin
      active_d = shadow_q;
      dirty_d  = '0;
    end else begin
      active_d = active_q;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      shadow_d[i*DATA_W +: DATA_W] = (data_wr_s && (address == 9'(i))) ?
                                     writedata[DATA_W-1:0] : shadow_d[i*DATA_W +: DATA_W];
      dirty_d[i] = dirty_d[i] | (data_wr_s && (address == 9'(i)));
    end
    ctrl_d         = ctrl_wr_s ? writedata[1:0] : ctrl_q;
    commit_pulse_d = commit_s;
    pending_d      = |dirty_d;
  end

  // Frame counter and animation phases.
  always_comb begin
    frame_d = vb_start_s ? (frame_q + 16'd1) : frame_q;
    anim_d  = anim_q;
    walk_d  = walk_q;
    flap_d  = flap_q;
    if (anim_wrap_s) begin
      anim_d = '0;
      walk_d = (walk_q == 2'd2) ? 2'd0 : (walk_q + 2'd1);
      flap_d = ~flap_q;
    end else if (anim_run_s) begin
      anim_d = anim_q + AW'(1);
    end else begin
      anim_d = anim_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_q       <= '0;
      active_q       <= '0;
      dirty_q        <= '0;
      ctrl_q         <= 2'd0;
      commit_pulse_q <= 1'b0;
      pending_q      <= 1'b0;
      frame_q        <= 16'd0;
      anim_q         <= '0;
      walk_q         <= 2'd0;
      flap_q         <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      dirty_q        <= dirty_d;
      ctrl_q         <= ctrl_d;
      commit_pulse_q <= commit_pulse_d;
      pending_q      <= pending_d;
      frame_q        <= frame_d;
      anim_q         <= anim_d;
      walk_q         <= walk_d;
      flap_q         <= flap_d;
    end
  end

  assign active_regs  = active_q;
  assign commit_pulse = commit_pulse_q;
  assign pending      = pending_q;
  assign frame_count  = frame_q;
  assign walk_phase   = walk_q;
  assign flap_phase   = flap_q;

endmodule

// File: tb/tb_sprite_frame_sequencer.sv
// Scoreboard bench for sprite_frame_sequencer: each commit pushes the expected bank,
// a negedge monitor pops and compares whenever commit_pulse is seen.
module tb_sprite_frame_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         chipselect;
  logic         write;
  logic [8:0]   address;
  logic [31:0]  writedata;
  logic [10:0]  hcount;
  logic [9:0]   vcount;
  logic [159:0] active_regs;
  logic         commit_pulse;
  logic         pending;
  logic [15:0]  frame_count;
  logic [1:0]   walk_phase;
  logic         flap_phase;

  int checks = 0;
  int errors = 0;

  logic [159:0] exp_q[$];
  logic [159:0] m_shadow;
  logic [15:0]  m_dirty;
  logic         m_freeze;
  int           m_frame;

  always #10 clk = ~clk;

  sprite_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .hcount(hcount), .vcount(vcount),
    .active_regs(active_regs), .commit_pulse(commit_pulse), .pending(pending),
    .frame_count(frame_count), .walk_phase(walk_phase), .flap_phase(flap_phase)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] reg_of(input int i);
    return active_regs[i*10 +: 10];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_dirty  = '0;
    m_freeze = 1'b0;
    m_frame  = 0;
    exp_q.delete();
  endtask

  task automatic model_wr(input logic [8:0] a, input logic [31:0] d);
    if (a < 9'd15) begin
      m_shadow[a*10 +: 10] = d[9:0];
      m_dirty[a] = 1'b1;
    end else if (a == 9'd15) begin
      m_freeze = d[0];
    end
  endtask

  task automatic bus_on(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
  endtask

  task automatic bus_off();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    bus_on(a, d);
    model_wr(a, d);
    tick();
    bus_off();
  endtask

  // One vb_start cycle, optionally with a coincident bus write.
  task automatic vb_wr(input bit do_wr, input logic [8:0] a, input logic [31:0] d);
    hcount = 11'd1599;
    vcount = 10'd479;
    if (do_wr) bus_on(a, d);
    if (!m_freeze) begin
      exp_q.push_back(m_shadow);
      m_dirty = '0;
    end
    m_frame++;
    if (do_wr) model_wr(a, d);
    tick();
    bus_off();
    hcount = 11'd0;
    vcount = 10'd100;
  endtask

  task automatic vb();
    vb_wr(1'b0, 9'd0, 32'd0);
  endtask

  // Monitor: every commit_pulse must match the oldest queued bank.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && commit_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("commit_unexpected", {159'd0, commit_pulse}, 160'd0);
      end else begin
        check("commit_bank", active_regs, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus_off();
    address   = 9'd0;
    writedata = 32'd0;
    hcount    = 11'd0;
    vcount    = 10'd100;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;

    check("rst_active", active_regs, 160'd0);
    check("rst_commit_pulse", {159'd0, commit_pulse}, 160'd0);
    check("rst_pending", {159'd0, pending}, 160'd0);
    check("rst_frame_count", {144'd0, frame_count}, 160'd0);
    check("rst_walk", {158'd0, walk_phase}, 160'd0);
    check("rst_flap", {159'd0, flap_phase}, 160'd0);

    // Animation: phases after 6, 12, 18 frames, then hold under PAUSE.
    for (int i = 0; i < 6; i++) vb();
    check("walk_6", {158'd0, walk_phase}, 160'd1);
    check("flap_6", {159'd0, flap_phase}, 160'd1);
    for (int i = 0; i < 6; i++) vb();
    check("walk_12", {158'd0, walk_phase}, 160'd2);
    check("flap_12", {159'd0, flap_phase}, 160'd0);
    for (int i = 0; i < 6; i++) vb();
    check("walk_18", {158'd0, walk_phase}, 160'd0);
    check("flap_18", {159'd0, flap_phase}, 160'd1);
    check("frame_18", {144'd0, frame_count}, 160'd18);
    wr(9'd15, 32'd2);
    for (int i = 0; i < 10; i++) vb();
    check("walk_paused", {158'd0, walk_phase}, 160'd0);
    check("flap_paused", {159'd0, flap_phase}, 160'd1);
    check("frame_28", {144'd0, frame_count}, 160'd28);
    wr(9'd15, 32'd0);

    // Write lands in shadow only until vb_start.
    wr(9'd0, 32'h064);
    check("t1_reg0_before", {150'd0, reg_of(0)}, 160'd0);
    check("t1_pending_before", {159'd0, pending}, 160'd1);
    vb();
    check("t1_reg0_after", {150'd0, reg_of(0)}, 160'h064);
    check("t1_commit_pulse", {159'd0, commit_pulse}, 160'd1);
    tick();
    check("t1_commit_pulse_once", {159'd0, commit_pulse}, 160'd0);
    check("t1_pending_after", {159'd0, pending}, 160'd0);

    // Write coinciding with vb_start: old shadow commits, new one waits a frame.
    wr(9'd3, 32'h011);
    vb();
    vb_wr(1'b1, 9'd3, 32'h2AA);
    check("t2_reg3_old", {150'd0, reg_of(3)}, 160'h011);
    check("t2_pending", {159'd0, pending}, 160'd1);
    vb();
    check("t2_reg3_new", {150'd0, reg_of(3)}, 160'h2AA);
    check("t2_pending_clear", {159'd0, pending}, 160'd0);

    // FREEZE suppresses commits but not frame counting.
    wr(9'd15, 32'd1);
    wr(9'd1, 32'h050);
    for (int i = 0; i < 3; i++) vb();
    check("t3_reg1_frozen", {150'd0, reg_of(1)}, 160'd0);
    check("t3_pending_frozen", {159'd0, pending}, 160'd1);
    check("t3_frame_count", {144'd0, frame_count}, 160'(m_frame));
    wr(9'd15, 32'd0);
    vb();
    check("t3_reg1_released", {150'd0, reg_of(1)}, 160'h050);

    // Upper data bits dropped; out-of-range address has no effect.
    wr(9'd6, 32'hFFFFF3FF);
    vb();
    check("t5_reg6", {150'd0, reg_of(6)}, 160'h3FF);
    wr(9'd20, 32'h123);
    check("t5_pending_oor", {159'd0, pending}, 160'd0);
    vb();
    check("t5_reg6_kept", {150'd0, reg_of(6)}, 160'h3FF);

    // Mid-frame reset discards pending writes and a coincident write.
    for (int i = 0; i < 5; i++) wr(9'(i), 32'(i * 7 + 1));
    check("t6_pending_before", {159'd0, pending}, 160'd1);
    bus_on(9'd7, 32'h155);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus_off();
    model_reset();
    check("t6_active", active_regs, 160'd0);
    check("t6_pending", {159'd0, pending}, 160'd0);
    check("t6_commit_pulse", {159'd0, commit_pulse}, 160'd0);
    check("t6_frame_count", {144'd0, frame_count}, 160'd0);
    check("t6_walk", {158'd0, walk_phase}, 160'd0);
    check("t6_flap", {159'd0, flap_phase}, 160'd0);
    vb();
    check("t6_reg7_lost", {150'd0, reg_of(7)}, 160'd0);
    check("t6_frame_one", {144'd0, frame_count}, 160'd1);

    tick();
    tick();
    check("scoreboard_drain", 160'(exp_q.size()), 160'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
